// File: rtl/dsm2_sinc3_dec_if.sv
// Sample-side bundle of the sinc3 decimator: bitstream in, decimated samples out
// over valid/ready, plus the sticky overrun flag and its clear strobe.
interface dsm2_sinc3_dec_if #(
  parameter int DECIM = 64
);
  localparam int ACC_W = 3 * $clog2(DECIM) + 2;

  logic             en;
  logic             data_in;
  logic [ACC_W-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             overrun;
  logic             clr_ovr;

  // master = decimator (sample producer), slave = downstream consumer / stimulus
  modport master (
    input  en, data_in, dout_ready, clr_ovr,
    output dout, dout_valid, overrun
  );
  modport slave (
    output en, data_in, dout_ready, clr_ovr,
    input  dout, dout_valid, overrun
  );
endinterface

// File: rtl/dsm2_sinc3_dec.sv
// sinc3 (CIC) decimator for the 2nd-order delta-sigma bitstream: three integrators at
// modulator rate, three combs at the decimated rate, valid/ready sample output.
module dsm2_sinc3_dec #(
  parameter int DECIM = 64,
  parameter int SKIP  = 2
) (
  input  logic                   clk,
  input  logic                   rstx,
  dsm2_sinc3_dec_if.master       bus
);
  localparam int ACC_W = 3 * $clog2(DECIM) + 2;
  localparam int CNT_W = $clog2(DECIM);
  localparam int SKW   = ($clog2(SKIP + 1) > 0) ? $clog2(SKIP + 1) : 1;
  localparam logic [SKW-1:0]   SKIP_END = SKW'(SKIP);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  // Handshake: a sample transfers on a rising edge where dout_valid && dout_ready.
  // dout_valid stays high until that transfer; a newer sample may replace an
  // untaken one, which sets the sticky overrun flag.

  logic [ACC_W-1:0] r_i1, r_i2, r_i3;
  logic [ACC_W-1:0] r_d1, r_d2, r_d3;
  logic [ACC_W-1:0] r_dout;
  logic [CNT_W-1:0] r_cnt;
  logic [SKW-1:0]   r_skip;
  logic             r_tick;
  logic             r_valid;
  logic             r_ovr;

  logic [ACC_W-1:0] w_x;
  logic [ACC_W-1:0] w_i1, w_i2, w_i3;
  logic [ACC_W-1:0] w_c1, w_c2, w_c3;
  logic             w_tick, w_warm, w_load, w_take, w_ovr_set;

  // +1 / -1 in two's complement; all sums wrap modulo 2^ACC_W on purpose
  assign w_x  = bus.data_in ? ACC_W'(1) : {ACC_W{1'b1}};
  assign w_i1 = r_i1 + w_x;
  assign w_i2 = r_i2 + w_i1;
  assign w_i3 = r_i3 + w_i2;

  assign w_c1 = r_i3 - r_d1;
  assign w_c2 = w_c1 - r_d2;
  assign w_c3 = w_c2 - r_d3;

  assign w_tick    = bus.en && (r_cnt == CNT_LAST);
  assign w_warm    = (r_skip == SKIP_END);
  assign w_load    = r_tick && w_warm;
  assign w_take    = r_valid && bus.dout_ready;
  assign w_ovr_set = w_load && r_valid && !bus.dout_ready;

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      r_i1    <= '0;
      r_i2    <= '0;
      r_i3    <= '0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_d3    <= '0;
      r_dout  <= '0;
      r_cnt   <= '0;
      r_skip  <= '0;
      r_tick  <= 1'b0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (bus.en) begin
        r_i1  <= w_i1;
        r_i2  <= w_i2;
        r_i3  <= w_i3;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_tick <= w_tick;

      // comb runs one edge after the tick, on the settled i3
      if (r_tick) begin
        r_d1 <= r_i3;
        r_d2 <= w_c1;
        r_d3 <= w_c2;
        if (!w_warm) r_skip <= r_skip + SKW'(1);
      end

      if (w_load) begin
        r_dout  <= w_c3;
        r_valid <= 1'b1;
      end else if (w_take) begin
        r_valid <= 1'b0;
      end

      if (w_ovr_set)        r_ovr <= 1'b1;
      else if (bus.clr_ovr) r_ovr <= 1'b0;
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_valid;
  assign bus.overrun    = r_ovr;
endmodule

// File: tb/tb_dsm2_sinc3_dec.sv
// Self-checking bench for dsm2_sinc3_dec: impulse-response reference model at
// DECIM=4, plus a DECIM=64 instance fed from a behavioural 2nd-order modulator.
module tb_dsm2_sinc3_dec;
  localparam int D     = 4;
  localparam int SKIP  = 2;
  localparam int ACC_W = 3 * $clog2(D) + 2;
  localparam int D64   = 64;
  localparam int ACC64 = 3 * $clog2(D64) + 2;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstx = 1'b0;
  always #5 clk = ~clk;

  dsm2_sinc3_dec_if #(.DECIM(D))   bus4 ();
  dsm2_sinc3_dec_if #(.DECIM(D64)) bus64 ();

  dsm2_sinc3_dec #(.DECIM(D), .SKIP(SKIP)) u_dut (
    .clk (clk),
    .rstx(rstx),
    .bus (bus4)
  );

  dsm2_sinc3_dec #(.DECIM(D64), .SKIP(SKIP)) u_dut64 (
    .clk (clk),
    .rstx(rstx),
    .bus (bus64)
  );

  // ---------------- reference model state ----------------
  int               checks   = 0;
  int               failures = 0;
  int               h[3*D-2];          // sinc3 impulse response (three boxcars convolved)
  int               xs[$];             // accepted input symbols, +1/-1
  logic [ACC_W-1:0] exp_q[$];          // every sample the decimator should publish
  int               m_n, m_k;
  bit               m_pend, m_valid, m_ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void build_h();
    int b2[2*D-1];
    for (int i = 0; i < 2*D-1; i++) b2[i] = 0;
    for (int a = 0; a < D; a++)
      for (int b = 0; b < D; b++) b2[a+b]++;
    for (int m = 0; m < 3*D-2; m++) begin
      h[m] = 0;
      for (int c = 0; c < D; c++)
        if (m - c >= 0 && m - c < 2*D-1) h[m] += b2[m-c];
    end
  endfunction

  // k-th decimated output = symbols convolved with h, sampled at input index k*D
  function automatic logic [ACC_W-1:0] ref_y(input int k);
    longint acc = 0;
    int     j;
    for (int m = 0; m < 3*D-2; m++) begin
      j = k * D - m;
      if (j >= 1) acc += longint'(h[m]) * longint'(xs[j-1]);
    end
    return ACC_W'(acc);
  endfunction

  function automatic logic [ACC_W-1:0] last_y();
    if (exp_q.size() == 0) return '0;
    return exp_q[exp_q.size()-1];
  endfunction

  function automatic void model_reset();
    xs.delete();
    exp_q.delete();
    m_n = 0; m_k = 0;
    m_pend = 0; m_valid = 0; m_ovr = 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input bit e, input bit d, input bit rdy, input bit clr);
    bit was_valid, set;
    bus4.en = e; bus4.data_in = d; bus4.dout_ready = rdy; bus4.clr_ovr = clr;
    @(posedge clk);
    #1;
    was_valid = m_valid;
    set = 0;
    if (m_valid && rdy) m_valid = 0;
    if (m_pend) begin
      m_k++;
      if (m_k > SKIP) begin
        exp_q.push_back(ref_y(m_k));
        set = was_valid && !rdy;
        m_valid = 1;
      end
    end
    if (set)      m_ovr = 1;
    else if (clr) m_ovr = 0;
    m_pend = e && (((m_n + 1) % D) == 0);
    if (e) begin
      xs.push_back(d ? 1 : -1);
      m_n++;
    end
    chk("dout_valid", 32'(bus4.dout_valid), 32'(m_valid));
    chk("overrun",    32'(bus4.overrun),    32'(m_ovr));
    chk("dout",       32'(bus4.dout),       32'(last_y()));
  endtask

  task automatic do_reset();
    bus4.en = 0; bus4.data_in = 0; bus4.dout_ready = 0; bus4.clr_ovr = 0;
    bus64.en = 0; bus64.data_in = 0; bus64.dout_ready = 0; bus64.clr_ovr = 0;
    @(posedge clk);
    #3 rstx = 1'b0;
    #1;
    chk("rst_dout",    32'(bus4.dout),        32'd0);
    chk("rst_valid",   32'(bus4.dout_valid),  32'd0);
    chk("rst_ovr",     32'(bus4.overrun),     32'd0);
    chk("rst64_valid", 32'(bus64.dout_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rstx = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  real a1, a2, u;
  int  yb, v;

  initial begin
    build_h();
    do_reset();

    // full-scale +1
    for (int i = 0; i < 8*D; i++) step(1, 1, 1, 0);
    chk("const_pos", 32'(bus4.dout), 32'(8'sd64));

    // full-scale -1
    do_reset();
    for (int i = 0; i < 8*D; i++) step(1, 0, 1, 0);
    chk("const_neg", 32'(bus4.dout), 32'(8'hC0));

    // alternating 1,0
    do_reset();
    for (int i = 0; i < 8*D; i++) step(1, i[0] == 1'b0, 1, 0);
    chk("alt_zero", 32'(bus4.dout), 32'd0);

    // downstream stall across three published samples, then clear
    do_reset();
    for (int i = 0; i < 2*D; i++) step(1, 1, 1, 0);
    for (int i = 0; i < 3*D + 2; i++) step(1, 1, 0, 0);
    chk("stall_ovr",  32'(bus4.overrun), 32'd1);
    chk("stall_dout", 32'(bus4.dout),    32'(8'sd64));
    step(1, 1, 0, 1);
    chk("clr_ovr", 32'(bus4.overrun), 32'd0);

    // ready raised only on the load edge: consume-and-load, never overrun
    for (int i = 0; i < 4*D; i++) step(1, 1, m_pend, 0);
    chk("ready_on_load_ovr", 32'(bus4.overrun), 32'd0);

    // en toggling every cycle
    do_reset();
    for (int i = 0; i < 16*D; i++) step(i[0] == 1'b0, 1, 1, 0);
    chk("en_toggle", 32'(bus4.dout), 32'(8'sd64));

    // randomized traffic
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);

    // reset in the middle of a period, warm-up must restart
    do_reset();
    for (int i = 0; i < 2*D + 2; i++) step(1, 1, 1, 0);
    do_reset();
    for (int i = 0; i < 6*D; i++) step(1, 1, 1, 0);
    chk("mid_rst", 32'(bus4.dout), 32'(8'sd64));

    // DECIM=64 fed from a 2nd-order modulator model
    do_reset();
    a1 = 0.0; a2 = 0.0; u = 0.5;
    bus64.en = 1; bus64.dout_ready = 1; bus64.clr_ovr = 0;
    for (int i = 0; i < 8*D64; i++) begin
      yb = (a2 >= 0.0) ? 1 : -1;
      bus64.data_in = (yb > 0);
      a1 = a1 + u - real'(yb);
      a2 = a2 + a1 - real'(yb);
      step(0, 0, 1, 0);
    end
    v = int'($signed(bus64.dout));
    chk("dsm_half", 32'(v >= 131072 - 2048 && v <= 131072 + 2048), 32'd1);
    u = -0.25;
    for (int i = 0; i < 6*D64; i++) begin
      yb = (a2 >= 0.0) ? 1 : -1;
      bus64.data_in = (yb > 0);
      a1 = a1 + u - real'(yb);
      a2 = a2 + a1 - real'(yb);
      step(0, 0, 1, 0);
    end
    v = int'($signed(bus64.dout));
    chk("dsm_quarter_neg", 32'(v >= -65536 - 2048 && v <= -65536 + 2048), 32'd1);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
